// File: rtl/rc5_ctrl_pkg.sv
// Shared types and constants for the RC5 job controller.
package rc5_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {MODE_ENC = 1'b0, MODE_DEC = 1'b1} mode_t;

   localparam logic [4:0] RC5_DEFAULT_ROUNDS = 5'd12;
   localparam int         RC5_KEY_W          = 128;
   localparam int         RC5_WORD_W         = 32;
endpackage

// File: rtl/rc5_rr_arbiter.sv
// Two-way round-robin arbiter; last_grant only moves when the grant is consumed.
module rc5_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);
   logic last_grant_q, last_grant_d;

   always_comb begin
      grant = valid;
      if (valid == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      last_grant_d = last_grant_q;
      if (advance && (grant != 2'b00)) last_grant_d = grant[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_grant_q <= 1'b1;
      else     last_grant_q <= last_grant_d;
   end
endmodule

// File: rtl/rc5_job_ctrl.sv
// Sequences the RC5 core between two requesters and owns its key/rounds config.
// Optional watchdog abort of stuck jobs: define RC5_WATCHDOG_EN.
module rc5_job_ctrl
   import rc5_ctrl_pkg::*;
#(
   parameter int WDOG_CYCLES = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [RC5_KEY_W-1:0]  cfg_key,
   input  logic [4:0]            cfg_num_rounds,
   output logic                  cfg_busy,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_mode,
   input  logic [RC5_WORD_W-1:0] req0_data,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_mode,
   input  logic [RC5_WORD_W-1:0] req1_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [RC5_WORD_W-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  core_encrypt,
   output logic                  core_decrypt,
   output logic [4:0]            core_num_rounds,
   output logic [RC5_KEY_W-1:0]  core_key,
   output logic [RC5_WORD_W-1:0] core_d_in,
   input  logic [RC5_WORD_W-1:0] core_d_out,
   input  logic                  core_done
);
   state_t                  state_q, state_d;
   logic                    id_q, id_d;
   mode_t                   mode_q, mode_d;
   logic [RC5_WORD_W-1:0]   din_q, din_d;
   logic [RC5_WORD_W-1:0]   rsp_data_q, rsp_data_d;
   logic [RC5_KEY_W-1:0]    key_q, key_d;
   logic [4:0]              rounds_q, rounds_d;
   logic [1:0]              grant;
   logic                    accept;
`ifdef RC5_WATCHDOG_EN
   localparam logic [10:0] WDOG_LIMIT = 11'(WDOG_CYCLES - 1);
   logic [10:0]             wdog_q, wdog_d;
   logic                    rsp_err_q, rsp_err_d;
`endif

   rc5_rr_arbiter u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   ({req1_valid, req0_valid}),
      .advance (accept),
      .grant   (grant)
   );

   // Ready is gated by rst so it reads 0 the moment reset asserts.
   assign req0_ready = !rst && (state_q == IDLE) && grant[0];
   assign req1_ready = !rst && (state_q == IDLE) && grant[1];
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   assign cfg_busy        = (state_q != IDLE);
   assign rsp_id          = id_q;
   assign rsp_data        = rsp_data_q;
   assign core_d_in       = din_q;
   assign core_key        = key_q;
   assign core_num_rounds = rounds_q;
`ifdef RC5_WATCHDOG_EN
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      mode_d       = mode_q;
      din_d        = din_q;
      rsp_data_d   = rsp_data_q;
      key_d        = key_q;
      rounds_d     = rounds_q;
      core_encrypt = 1'b0;
      core_decrypt = 1'b0;
      rsp_valid    = 1'b0;
`ifdef RC5_WATCHDOG_EN
      wdog_d       = wdog_q;
      rsp_err_d    = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (cfg_we) begin
               key_d = cfg_key;
               if (cfg_num_rounds != 5'd0) rounds_d = cfg_num_rounds;
            end
            if (accept) begin
               id_d    = grant[1];
               mode_d  = mode_t'(grant[1] ? req1_mode : req0_mode);
               din_d   = grant[1] ? req1_data : req0_data;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            core_encrypt = (mode_q == MODE_ENC);
            core_decrypt = (mode_q == MODE_DEC);
            state_d      = WAIT;
`ifdef RC5_WATCHDOG_EN
            wdog_d       = 11'd0;
`endif
         end
         WAIT: begin
            if (core_done) begin
               rsp_data_d = core_d_out;
               state_d    = RESP;
`ifdef RC5_WATCHDOG_EN
               rsp_err_d  = 1'b0;
            end else if (wdog_q == WDOG_LIMIT) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end else begin
               wdog_d     = wdog_q + 11'd1;
`endif
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         id_q       <= 1'b0;
         mode_q     <= MODE_ENC;
         din_q      <= '0;
         rsp_data_q <= '0;
         key_q      <= '0;
         rounds_q   <= RC5_DEFAULT_ROUNDS;
`ifdef RC5_WATCHDOG_EN
         wdog_q     <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         mode_q     <= mode_d;
         din_q      <= din_d;
         rsp_data_q <= rsp_data_d;
         key_q      <= key_d;
         rounds_q   <= rounds_d;
`ifdef RC5_WATCHDOG_EN
         wdog_q     <= wdog_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end
endmodule
